vram_sched: RTL and testbench

- Time-slot scheduler in front of the vdp99 vram block; the vram CPU port and DMA read port never tick in the same cycle.
- Per 8-clock character cell, issues three DMA reads (name, pattern, color) for Graphics I rendering.
- Defers CPU bus rd/wr ticks into free slots and hands fetched bytes to the pixel pipeline.

---
 rtl/vdp99_pkg.sv | 22 ++
 rtl/vram_cpu_slot.sv | 67 ++++++
 rtl/vram_sched.sv | 153 +++++++++++++++
 tb/tb_vram_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp99_pkg.sv
// Shared constants for the vdp99 VRAM scheduler: slot numbering within an
// 8-clock character cell, default address width and the scheduler state type.
package vdp99_pkg;

  localparam int VRAM_ADDR_WIDTH = 13;

  localparam logic [2:0] SLOT_NAME  = 3'd0;
  localparam logic [2:0] SLOT_PAT   = 3'd2;
  localparam logic [2:0] SLOT_COL   = 3'd4;
  localparam logic [2:0] SLOT_VALID = 3'd6;
  localparam logic [2:0] SLOT_LAST  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } sched_state_t;

  function automatic logic is_dma_slot(input logic [2:0] slot);
    return (slot == SLOT_NAME) || (slot == SLOT_PAT) || (slot == SLOT_COL);
  endfunction

endpackage

// File: rtl/vram_cpu_slot.sv
// One-deep CPU request buffer: captures a rd/wr strobe and replays it to the
// vram port on the first cycle the scheduler marks as a CPU slot.
module vram_cpu_slot (
  input  logic clk,
  input  logic reset,
  input  logic cpu_slot,
  input  logic cpu_rd_tick,
  input  logic cpu_wr_tick,
  input  logic cpu_mode,
  output logic vram_rd_tick,
  output logic vram_wr_tick,
  output logic vram_mode,
  output logic cpu_busy,
  output logic cpu_overrun
);

  logic pending_reg, pending_next;
  logic write_reg, write_next;
  logic mode_reg, mode_next;
  logic overrun_reg, overrun_next;
  logic issue;
  logic any_tick;

  always_comb begin
    pending_next = pending_reg;
    write_next   = write_reg;
    mode_next    = mode_reg;
    overrun_next = overrun_reg;
    any_tick     = cpu_rd_tick | cpu_wr_tick;
    issue        = pending_reg & cpu_slot;

    if (issue) pending_next = 1'b0;

    // The buffer is still occupied on its issue cycle, so a strobe then is lost.
    if (any_tick) begin
      if (pending_reg) begin
        overrun_next = 1'b1;
      end else begin
        pending_next = 1'b1;
        write_next   = cpu_wr_tick;
        mode_next    = cpu_mode;
        if (cpu_rd_tick && cpu_wr_tick) overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
      write_reg   <= 1'b0;
      mode_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      write_reg   <= write_next;
      mode_reg    <= mode_next;
      overrun_reg <= overrun_next;
    end
  end

  assign vram_rd_tick = issue & ~write_reg;
  assign vram_wr_tick = issue & write_reg;
  assign vram_mode    = issue & mode_reg;
  assign cpu_busy     = pending_reg;
  assign cpu_overrun  = overrun_reg;

endmodule

// File: rtl/vram_sched.sv
// Time-slot scheduler in front of the vdp99 vram: three DMA reads per
// 8-clock Graphics I cell, CPU accesses deferred into the remaining slots.
module vram_sched
  import vdp99_pkg::*;
#(
  parameter int  VRAM_SIZE = 8192,
  parameter int  CELLS     = 32,
  localparam int AW        = $clog2(VRAM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  input  logic          line_start,
  input  logic [7:0]    line,
  input  logic [3:0]    name_base,
  input  logic [2:0]    pattern_base,
  input  logic [7:0]    color_base,
  input  logic          cpu_rd_tick,
  input  logic          cpu_wr_tick,
  input  logic          cpu_mode,
  output logic          vram_rd_tick,
  output logic          vram_wr_tick,
  output logic          vram_mode,
  output logic [AW-1:0] dma_addr,
  output logic          dma_rd_tick,
  input  logic [7:0]    dma_din,
  output logic [7:0]    name_byte,
  output logic [7:0]    pattern_byte,
  output logic [7:0]    color_byte,
  output logic [4:0]    cell_col,
  output logic          cell_valid,
  output logic          cpu_busy,
  output logic          cpu_overrun
);

  localparam logic [4:0] LAST_COL = 5'(CELLS - 1);

  sched_state_t state_reg, state_next;
  logic [2:0]    slot_reg, slot_next;
  logic [4:0]    col_reg, col_next;
  logic [7:0]    line_reg, line_next;
  logic [7:0]    name_reg, name_next;
  logic [7:0]    pat_reg, pat_next;
  logic [7:0]    color_reg, color_next;
  logic [AW-1:0] addr_hold_reg;
  logic [AW-1:0] addr_calc;
  logic          dma_tick;
  logic          cpu_slot;

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    col_next   = col_reg;
    line_next  = line_reg;
    name_next  = name_reg;
    pat_next   = pat_reg;
    color_next = color_reg;
    dma_tick   = 1'b0;
    addr_calc  = addr_hold_reg;

    if (state_reg == ST_FETCH) begin
      case (slot_reg)
        SLOT_NAME: begin
          dma_tick  = 1'b1;
          addr_calc = AW'({name_base, line_reg[7:3], col_reg});
        end
        SLOT_PAT: begin
          dma_tick  = 1'b1;
          addr_calc = AW'({pattern_base, name_reg, line_reg[2:0]});
        end
        SLOT_COL: begin
          dma_tick  = 1'b1;
          addr_calc = AW'({color_base, 6'b0} | {9'b0, name_reg[7:3]});
        end
        SLOT_NAME + 3'd1: name_next  = dma_din;
        SLOT_PAT + 3'd1:  pat_next   = dma_din;
        SLOT_COL + 3'd1:  color_next = dma_din;
        default: ;
      endcase

      if (slot_reg == SLOT_LAST) begin
        slot_next = 3'd0;
        if (col_reg == LAST_COL) begin
          state_next = ST_IDLE;
          col_next   = 5'd0;
        end else begin
          col_next = col_reg + 5'd1;
        end
      end else begin
        slot_next = slot_reg + 3'd1;
      end
    end

    // line_start overrides everything: restart, or drop to IDLE without display enable.
    if (line_start) begin
      state_next = fetch_en ? ST_FETCH : ST_IDLE;
      slot_next  = 3'd0;
      col_next   = 5'd0;
      line_next  = line;
      name_next  = 8'd0;
      pat_next   = 8'd0;
      color_next = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      slot_reg      <= 3'd0;
      col_reg       <= 5'd0;
      line_reg      <= 8'd0;
      name_reg      <= 8'd0;
      pat_reg       <= 8'd0;
      color_reg     <= 8'd0;
      addr_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      col_reg       <= col_next;
      line_reg      <= line_next;
      name_reg      <= name_next;
      pat_reg       <= pat_next;
      color_reg     <= color_next;
      addr_hold_reg <= dma_addr;
    end
  end

  assign dma_rd_tick  = dma_tick;
  assign dma_addr     = addr_calc;
  assign name_byte    = name_reg;
  assign pattern_byte = pat_reg;
  assign color_byte   = color_reg;
  assign cell_col     = col_reg;
  assign cell_valid   = (state_reg == ST_FETCH) && (slot_reg == SLOT_VALID);

  // DMA and CPU slots are complementary, so the two vram ports never tick together.
  assign cpu_slot = (state_reg == ST_IDLE) || !is_dma_slot(slot_reg);

  vram_cpu_slot u_cpu_slot (
    .clk          (clk),
    .reset        (reset),
    .cpu_slot     (cpu_slot),
    .cpu_rd_tick  (cpu_rd_tick),
    .cpu_wr_tick  (cpu_wr_tick),
    .cpu_mode     (cpu_mode),
    .vram_rd_tick (vram_rd_tick),
    .vram_wr_tick (vram_wr_tick),
    .vram_mode    (vram_mode),
    .cpu_busy     (cpu_busy),
    .cpu_overrun  (cpu_overrun)
  );

endmodule

// File: tb/tb_vram_sched.sv
// Directed bench for vram_sched: cell fetch addresses, full line, CPU slotting,
// overrun, restart and asynchronous reset, with hand-computed expectations.
module tb_vram_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        line_start;
  logic [7:0]  line;
  logic [3:0]  name_base;
  logic [2:0]  pattern_base;
  logic [7:0]  color_base;
  logic        cpu_rd_tick;
  logic        cpu_wr_tick;
  logic        cpu_mode;
  logic        vram_rd_tick;
  logic        vram_wr_tick;
  logic        vram_mode;
  logic [12:0] dma_addr;
  logic        dma_rd_tick;
  logic [7:0]  dma_din;
  logic [7:0]  name_byte;
  logic [7:0]  pattern_byte;
  logic [7:0]  color_byte;
  logic [4:0]  cell_col;
  logic        cell_valid;
  logic        cpu_busy;
  logic        cpu_overrun;

  int n_checks  = 0;
  int n_fail    = 0;
  int conflicts = 0;
  int ticks;
  int valids;
  int errs;
  logic [12:0] last_name_addr;

  always #20 clk = ~clk;

  vram_sched #(.VRAM_SIZE(8192), .CELLS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .line_start   (line_start),
    .line         (line),
    .name_base    (name_base),
    .pattern_base (pattern_base),
    .color_base   (color_base),
    .cpu_rd_tick  (cpu_rd_tick),
    .cpu_wr_tick  (cpu_wr_tick),
    .cpu_mode     (cpu_mode),
    .vram_rd_tick (vram_rd_tick),
    .vram_wr_tick (vram_wr_tick),
    .vram_mode    (vram_mode),
    .dma_addr     (dma_addr),
    .dma_rd_tick  (dma_rd_tick),
    .dma_din      (dma_din),
    .name_byte    (name_byte),
    .pattern_byte (pattern_byte),
    .color_byte   (color_byte),
    .cell_col     (cell_col),
    .cell_valid   (cell_valid),
    .cpu_busy     (cpu_busy),
    .cpu_overrun  (cpu_overrun)
  );

  always @(negedge clk) begin
    if (dma_rd_tick && (vram_rd_tick || vram_wr_tick)) conflicts++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 'h%0h", tag, obs);
    end
  endtask

  // Small vram contents: three known cell bytes, everything else a simple pattern.
  function automatic logic [7:0] mem_rd(input logic [12:0] a);
    case (a)
      13'h1820: return 8'h41;
      13'h0209: return 8'h3C;
      13'h1FC8: return 8'hF1;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Advance to the next falling edge; vram read data appears the cycle after a tick.
  task automatic cyc();
    @(negedge clk);
    if (dma_rd_tick) dma_din = mem_rd(dma_addr);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; line_start = 1'b0; line = 8'd0;
    name_base = 4'd0; pattern_base = 3'd0; color_base = 8'd0;
    cpu_rd_tick = 1'b0; cpu_wr_tick = 1'b0; cpu_mode = 1'b0; dma_din = 8'd0;
    cyc(); cyc();
    check_eq("reset_flags", 32'({dma_rd_tick, vram_rd_tick, vram_wr_tick, vram_mode,
                                 cell_valid, cpu_busy, cpu_overrun}), 0);
    check_eq("reset_addr", 32'(dma_addr), 0);
    check_eq("reset_bytes", 32'({name_byte, pattern_byte, color_byte, cell_col}), 0);
    reset = 1'b0;
    cyc();

    // Single cell: name_base=6, pattern_base=0, color_base=7F, line 9.
    name_base = 4'd6; pattern_base = 3'd0; color_base = 8'h7F; line = 8'd9;
    fetch_en = 1'b1; line_start = 1'b1;
    cyc(); line_start = 1'b0;
    check_eq("s0_tick", 32'(dma_rd_tick), 1);
    check_eq("s0_name_addr", 32'(dma_addr), 'h1820);
    cyc();
    check_eq("s1_no_tick", 32'(dma_rd_tick), 0);
    check_eq("s1_addr_hold", 32'(dma_addr), 'h1820);
    cyc();
    check_eq("s2_pat_addr", 32'({dma_rd_tick, dma_addr}), 'h2209);
    check_eq("s2_name_byte", 32'(name_byte), 'h41);
    cyc(); cyc();
    check_eq("s4_col_addr", 32'({dma_rd_tick, dma_addr}), 'h3FC8);
    check_eq("s4_pattern_byte", 32'(pattern_byte), 'h3C);
    cyc(); cyc();
    check_eq("s6_valid_col", 32'({cell_valid, cell_col}), 'h20);
    check_eq("s6_bytes", 32'({name_byte, pattern_byte, color_byte}), 'h413CF1);

    // Full line from a restart at s6.
    line_start = 1'b1;
    ticks = 0; valids = 0; errs = 0; last_name_addr = '0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 0) line_start = 1'b0;
      if (dma_rd_tick) ticks++;
      if (dma_rd_tick != (i < 256 && (i % 8 == 0 || i % 8 == 2 || i % 8 == 4))) errs++;
      if (cell_valid) begin
        valids++;
        if (i % 8 != 6 || cell_col != 5'(i / 8)) errs++;
      end
      if (i == 248) last_name_addr = dma_addr;
    end
    check_eq("line_dma_ticks", ticks, 96);
    check_eq("line_cell_valids", valids, 32);
    check_eq("line_slot_pattern", errs, 0);
    check_eq("line_col31_addr", 32'(last_name_addr), 'h183F);

    // CPU writes deferred past DMA slots.
    line_start = 1'b1;
    cyc(); line_start = 1'b0;
    cpu_wr_tick = 1'b1; cpu_mode = 1'b0;
    cyc(); cpu_wr_tick = 1'b0;
    check_eq("wr_a_issue_s1", 32'({vram_wr_tick, vram_rd_tick, dma_rd_tick, cpu_busy}), 'b1001);
    cyc();
    check_eq("wr_a_done_s2", 32'({vram_wr_tick, cpu_busy, dma_rd_tick}), 'b001);
    cpu_wr_tick = 1'b1;
    cyc(); cpu_wr_tick = 1'b0;
    check_eq("wr_b_issue_s3", 32'({vram_wr_tick, cpu_busy}), 'b11);
    cyc();
    check_eq("wr_b_done_s4", 32'({vram_wr_tick, cpu_busy, dma_rd_tick}), 'b001);
    cyc(); cyc(); cyc();
    cpu_rd_tick = 1'b1; cpu_mode = 1'b1;
    cyc(); cpu_rd_tick = 1'b0; cpu_mode = 1'b0;
    check_eq("rd_deferred_s0", 32'({vram_rd_tick, cpu_busy, dma_rd_tick}), 'b011);
    cyc();
    check_eq("rd_issue_s1", 32'({vram_rd_tick, vram_mode, cpu_overrun}), 'b110);

    // Restart from col 10 slot 3 with a new line.
    for (int i = 0; i < 74; i++) cyc();
    check_eq("pre_restart_col", 32'(cell_col), 10);
    line = 8'd17; line_start = 1'b1;
    cyc(); line_start = 1'b0;
    check_eq("restart_name_addr", 32'({dma_rd_tick, dma_addr}), 'h3840);
    check_eq("restart_discard", 32'({name_byte, pattern_byte, color_byte, cell_col}), 0);
    cyc();
    fetch_en = 1'b0; line_start = 1'b1;
    cyc(); line_start = 1'b0;
    check_eq("stop_no_tick", 32'(dma_rd_tick), 0);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (dma_rd_tick || cell_valid) errs++;
    end
    check_eq("idle_quiet", errs, 0);

    // IDLE: status read forwarded next clock, back-to-back strobe dropped.
    cpu_rd_tick = 1'b1; cpu_mode = 1'b1;
    cyc();
    check_eq("idle_rd_issue", 32'({vram_rd_tick, vram_mode, cpu_busy, cpu_overrun}), 'b1110);
    cyc(); cpu_rd_tick = 1'b0; cpu_mode = 1'b0;
    check_eq("idle_rd_dropped", 32'({vram_rd_tick, cpu_busy, cpu_overrun}), 'b001);
    cpu_rd_tick = 1'b1; cpu_wr_tick = 1'b1;
    cyc(); cpu_rd_tick = 1'b0; cpu_wr_tick = 1'b0;
    check_eq("rd_wr_takes_wr", 32'({vram_wr_tick, vram_rd_tick, vram_mode}), 'b100);
    cyc(); cyc(); cyc();
    check_eq("overrun_sticky", 32'(cpu_overrun), 1);

    // Asynchronous reset in the middle of a cell at slot 2.
    fetch_en = 1'b1; line_start = 1'b1;
    cyc(); line_start = 1'b0;
    cyc(); cyc();
    check_eq("pre_reset_s2_tick", 32'(dma_rd_tick), 1);
    reset = 1'b1;
    #1;
    check_eq("async_reset_flags", 32'({dma_rd_tick, vram_rd_tick, vram_wr_tick, vram_mode,
                                       cell_valid, cpu_busy, cpu_overrun}), 0);
    check_eq("async_reset_addr", 32'(dma_addr), 0);
    check_eq("async_reset_bytes", 32'({name_byte, pattern_byte, color_byte, cell_col}), 0);
    cyc(); reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (dma_rd_tick) ticks++;
    end
    check_eq("post_reset_idle", ticks, 0);
    check_eq("port_exclusive", conflicts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
